// File: rtl/tlc_pkg.sv
// Shared traffic-light definitions: FSM state codes, phase classes and the
// timer controller states used alongside the controller FSM.
package tlc_pkg;

    localparam logic [3:0] ST_ALL_RED     = 4'd0;
    localparam logic [3:0] ST_NS_GREEN    = 4'd1;
    localparam logic [3:0] ST_NS_EXTEND   = 4'd2;
    localparam logic [3:0] ST_NS_YELLOW   = 4'd3;
    localparam logic [3:0] ST_EW_GREEN    = 4'd4;
    localparam logic [3:0] ST_EW_EXTEND   = 4'd5;
    localparam logic [3:0] ST_EW_YELLOW   = 4'd6;
    localparam logic [3:0] ST_NSL_GREEN   = 4'd7;
    localparam logic [3:0] ST_NSL_EXTEND  = 4'd8;
    localparam logic [3:0] ST_NSL_YELLOW  = 4'd9;
    localparam logic [3:0] ST_EWL_GREEN   = 4'd10;
    localparam logic [3:0] ST_EWL_EXTEND  = 4'd11;
    localparam logic [3:0] ST_EWL_YELLOW  = 4'd12;

    typedef enum logic [1:0] {
        PH_RED,
        PH_PRIMARY,
        PH_EXTENDED,
        PH_YELLOW
    } phase_class_t;

    typedef enum logic [1:0] {
        TS_LOAD,
        TS_COUNT,
        TS_EXPIRE
    } timer_state_t;

    // Unused codes 13-15 fall through to RED so a corrupted state fails safe.
    function automatic phase_class_t state_to_class(input logic [3:0] code);
        case (code)
            ST_NS_GREEN, ST_EW_GREEN, ST_NSL_GREEN, ST_EWL_GREEN:     return PH_PRIMARY;
            ST_NS_EXTEND, ST_EW_EXTEND, ST_NSL_EXTEND, ST_EWL_EXTEND: return PH_EXTENDED;
            ST_NS_YELLOW, ST_EW_YELLOW, ST_NSL_YELLOW, ST_EWL_YELLOW: return PH_YELLOW;
            default:                                                  return PH_RED;
        endcase
    endfunction

    function automatic logic [7:0] sat8(input int unsigned v);
        return (v > 255) ? 8'hFF : 8'(v);
    endfunction

endpackage

// File: rtl/phase_timer_sec_prescaler.sv
// Clock-to-seconds prescaler: counts enabled cycles and emits a one-cycle
// sec_tick on the cycle that wraps the count.
module sec_prescaler #(
    parameter int unsigned CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic sec_tick
);

    localparam int unsigned PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_SEC - 1);

    logic [PW-1:0] presc_reg;

    // Disabled cycles (hold or abort) never tick, even when the count sits at LAST.
    assign sec_tick = en && (presc_reg == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (clr || sec_tick) begin
            presc_reg <= '0;
        end else if (en) begin
            presc_reg <= presc_reg + PW'(1);
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Phase-duration timer: loads a per-phase duration from the FSM state code,
// counts it down in seconds and pulses expired for one cycle at the end.
module phase_timer
    import tlc_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = 50_000_000,
    parameter int unsigned T_ALL_RED   = 2,
    parameter int unsigned T_PRIMARY   = 10,
    parameter int unsigned T_EXTENDED  = 20,
    parameter int unsigned T_YELLOW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic       hold,
    output logic       expired,
    output logic [7:0] remaining
);

    localparam logic [7:0] D_RED      = sat8(T_ALL_RED);
    localparam logic [7:0] D_PRIMARY  = sat8(T_PRIMARY);
    localparam logic [7:0] D_EXTENDED = sat8(T_EXTENDED);
    localparam logic [7:0] D_YELLOW   = sat8(T_YELLOW);

    timer_state_t ctrl_reg, ctrl_next;
    logic [7:0]   sec_cnt_reg;
    logic [3:0]   latched_reg;
    logic [7:0]   duration;
    logic         load;
    logic         mismatch;
    logic         tick_en;
    logic         sec_tick;

    always_comb begin
        duration = D_RED;
        case (state_to_class(state))
            PH_PRIMARY:  duration = D_PRIMARY;
            PH_EXTENDED: duration = D_EXTENDED;
            PH_YELLOW:   duration = D_YELLOW;
            default:     duration = D_RED;
        endcase
    end

    assign load     = (ctrl_reg == TS_LOAD);
    assign mismatch = (state != latched_reg);
    // A state change outranks both hold and a pending wrap.
    assign tick_en  = (ctrl_reg == TS_COUNT) && !mismatch && !hold;

    sec_prescaler #(
        .CLK_PER_SEC(CLK_PER_SEC)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .clr     (load),
        .en      (tick_en),
        .sec_tick(sec_tick)
    );

    always_comb begin
        ctrl_next = ctrl_reg;
        case (ctrl_reg)
            TS_LOAD:   ctrl_next = (duration == 8'd0) ? TS_EXPIRE : TS_COUNT;
            TS_COUNT: begin
                if (mismatch) begin
                    ctrl_next = TS_LOAD;
                end else if (sec_tick && (sec_cnt_reg == 8'd1)) begin
                    ctrl_next = TS_EXPIRE;
                end
            end
            TS_EXPIRE: ctrl_next = TS_LOAD;
            default:   ctrl_next = TS_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_reg    <= TS_LOAD;
            sec_cnt_reg <= 8'd0;
            latched_reg <= 4'd0;
        end else begin
            ctrl_reg <= ctrl_next;
            if (load) begin
                latched_reg <= state;
                sec_cnt_reg <= duration;
            end else if (sec_tick) begin
                sec_cnt_reg <= sec_cnt_reg - 8'd1;
            end
        end
    end

    assign expired   = (ctrl_reg == TS_EXPIRE);
    assign remaining = sec_cnt_reg;

endmodule

// File: doc/phase_timer.md
# phase_timer

Phase-duration timer for the adaptive traffic-light controller. It watches the controller FSM's 4-bit `state` and loads a per-phase duration in seconds. It counts that duration down using a clock prescaler, then drives the single-cycle `expired` pulse that the FSM uses to advance. It is the timing half of the `expired` handshake, instantiated next to the FSM in the top level.

## Interface
- `CLK_PER_SEC`, 50_000_000: clock cycles per second; minimum 1.
- `T_ALL_RED`, 2: seconds for ALL_RED (code 0) and for invalid codes 13–15.
- `T_PRIMARY`, 10: seconds for PRIMARY_GREEN codes 1, 4, 7, 10.
- `T_EXTENDED`, 20: seconds for EXTENDED_GREEN codes 2, 5, 8, 11.
- `T_YELLOW`, 3: seconds for YELLOW codes 3, 6, 9, 12.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `state`  in  4  current FSM state code.
- `hold`  in  1  freezes the countdown while high (manual or emergency override).
- `expired`  out  1  registered one-cycle pulse: phase time elapsed.
- `remaining`  out  8  seconds left in the current phase.

## Operation
- The timer runs an internal controller with three states: LOAD, COUNT, EXPIRE.
- **Registers:** `presc` (width clog2(CLK_PER_SEC), minimum 1 bit), `sec_cnt[7:0]`, `latched_state[3:0]`.
- **Reset:** all registers are cleared and the controller enters LOAD. Outputs are `expired=0` and `remaining=0`.
- **LOAD** (always exactly 1 cycle):
  - Set `latched_state <= state`, `sec_cnt <= D`, where D = duration(class(state)), and `presc <= 0`.
  - If D == 0, go to EXPIRE; otherwise go to COUNT.
- **COUNT:**
  - If `state != latched_state`, go to LOAD (abort). This has priority over `hold` and over a prescaler wrap.
  - Else, if `hold`, nothing changes.
  - Else, if `presc == CLK_PER_SEC-1`: set `presc <= 0` and `sec_cnt <= sec_cnt-1`. If `sec_cnt == 1`, go to EXPIRE.
  - Else, `presc <= presc+1`.
- **EXPIRE** (exactly 1 cycle):
  - `expired = 1`. The FSM samples its next state at the closing edge.
  - Go to LOAD unconditionally, so the new `state` is sampled one cycle later.
  - `hold` and `state` changes are ignored here.
- **Outputs:**
  - `expired` is high only in EXPIRE and is decoded from the registered controller state.
  - `remaining = sec_cnt`. It is 0 in EXPIRE.
- **Widths:** durations are 8-bit and saturate at 255. A parameter above 255 is a configuration error.
- **Same-state re-entry** (for example, the FSM staying in ALL_RED with no traffic): this needs no special case, because EXPIRE→LOAD always reloads.

## Timing
- Phase period with no hold or abort: 1 (LOAD) + D·CLK_PER_SEC (COUNT) + 1 (EXPIRE) = D·CLK_PER_SEC + 2 cycles.
- This is also the spacing between consecutive `expired` pulses.
- D == 0 gives a 2-cycle period: LOAD, then EXPIRE.
- `remaining` decrements on the clock edge that wraps `presc`. It is visible the following cycle.
- `hold` asserted for H cycles during COUNT extends the period by exactly H cycles.
- An abort in COUNT restarts timing at the cycle after the mismatch is observed. No `expired` pulse is produced for the aborted phase.
- Reset mid-phase: `expired` drops immediately (asynchronously). The first LOAD happens on the first clock after `rst` is released.
- `expired` is never high for two consecutive cycles. It is never high in the first cycle after reset.

## Structure
- Shared package `tlc_pkg`:
  - The 4-bit state-code localparams, shared with the FSM so that neither block redefines them.
  - A 2-bit phase-class enum: RED, PRIMARY, EXTENDED, YELLOW.
  - A `state_to_class()` function that maps codes 13–15 to RED.
- One natural sub-module: `sec_prescaler`. It contains `presc`, the wrap detection, the `hold` gating and a synchronous clear, and outputs a one-cycle `sec_tick`.
- Controller, duration mux and `sec_cnt` stay in `phase_timer`.

## Test plan
- CLK_PER_SEC=4, T_ALL_RED=2; reset, hold `state`=0 → `expired` pulses first at cycle 10 after reset release, then every 10 cycles; `remaining` sequence 2,2,2,2,1,1,1,1,0.
- CLK_PER_SEC=4, T_YELLOW=3; drive `state`=3 → 14-cycle period. Driving `state`=2 with T_EXTENDED=20 → 82-cycle period.
- `hold`=1 for 5 cycles mid-COUNT with `state`=1, T_PRIMARY=10, CLK_PER_SEC=4 → `expired` arrives 5 cycles later than 42; `remaining` is frozen during the hold.
- Change `state` from 1 to 4 mid-COUNT → no `expired` pulse; `remaining` reloads to T_PRIMARY two cycles after the change.
- T_YELLOW=0, `state`=6 → `expired` pulses at 2-cycle intervals; `remaining`=0 throughout.
- Assert `rst` during EXPIRE → `expired` falls without waiting for a clock edge; `state`=15 after reset → loads T_ALL_RED.
